pipe_stage_skid: RTL and testbench

- Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
- Parametrised payload width.
- Successor to the fixed-width IF/ID-style stage registers: adds backpressure (stall), flush and a fully registered in_ready.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...). Upstream packs all stage fields into in_data.

---
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Handshake: a payload moves on any rising edge where valid and ready are both
  // high; valid never waits on ready, and in_ready depends only on registered state.

  // State bit 0 is main_v, bit 1 is skid_v; 2'b10 is illegal and never reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_skid: WIDTH and CNT_W must be at least 1");
  end

  assign main_v    = state[0];
  assign skid_v    = state[1];
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next     = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Data registers only move on real transfers, so bubbles and flushes hold them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (load_main) begin
        main_d <= main_from_skid ? skid_d : in_data;
      end
      if (load_skid) begin
        skid_d <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts cycles where a payload is offered but refused; flush does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: expected payloads queued at issue time,
// a negedge monitor pops and compares on every output transfer.
module tb_pipe_stage_skid;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int checks;
  int errors;

  pipe_stage_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver helpers: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge clk);
    check(name, act, exp);
  endtask

  // Scoreboard monitor: an output transfer will occur on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_data, 32'hxxxx_xxxx);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  localparam logic [31:0] A = 32'hA5A5_A5A5;
  localparam logic [31:0] B = 32'h5A5A_5A5A;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    mid_check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;

    // Streaming 1..8, one per cycle, latency 1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      exp_q.push_back(i);
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 1) check("stream_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    mid_check("stream_last_valid", {31'd0, out_valid}, 32'd1);
    step();
    mid_check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A then B held, then drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    exp_q.push_back(A);
    step();
    in_data = B;
    exp_q.push_back(B);
    mid_check("bp_ready_one", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    mid_check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_head_data", out_data, A);
    step();
    mid_check("bp_ready_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    mid_check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check("bp_second_data", out_data, B);
    step();
    mid_check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush in FULL, then C only
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    step();
    in_data = B;
    step();
    in_valid = 1'b0;
    mid_check("fl_full_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    mid_check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hC;
    exp_q.push_back(32'hC);
    step();
    in_valid = 1'b0;
    mid_check("fl_c_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Flush coincident with D in EMPTY: D is discarded
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    mid_check("fl_d_gone", {31'd0, out_valid}, 32'd0);
    step();
    mid_check("fl_d_gone2", {31'd0, out_valid}, 32'd0);

    // Flush while the held payload is consumed in the same cycle
    in_valid = 1'b1;
    in_data  = 32'h77;
    exp_q.push_back(32'h77);
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    mid_check("fl_consumed", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hE;
    exp_q.push_back(32'hE);
    step();
    in_valid = 1'b0;
    mid_check("post_rst_e_valid", {31'd0, out_valid}, 32'd1);
    step();

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter: 10 stalled cycles, then saturation, then survives flush
    mid_check("stall_zero", {28'd0, stall_cnt}, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    mid_check("stall_10", {28'd0, stall_cnt}, 32'd10);
    repeat (10) step();
    mid_check("stall_sat", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    mid_check("stall_after_flush", {28'd0, stall_cnt}, 32'd15);
    out_ready = 1'b1;
    step();
`endif

    step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
